// File: rtl/rrt_sample_gen.sv
// rrt_sample_gen: turns xorshift64 words into uniform 2-D sample points inside
// [0, X_MAX) x [0, Y_MAX) by mask-and-reject, substitutes the goal point on
// every GOAL_PERIOD-th emitted sample, and offers one point at a time to the
// nearest-neighbour stage.
//
// Handshake: sample_valid rises with stable sample_x/sample_y/sample_is_goal
// and stays high, with those outputs frozen, until the cycle in which
// sample_valid && sample_ready is seen at a rising edge; that edge is the
// transfer, and sample_valid is never withdrawn before it.
module rrt_sample_gen #(
  parameter int unsigned     COORD_W     = 16,
  parameter longint unsigned X_MAX       = 1024,
  parameter longint unsigned Y_MAX       = 1024,
  parameter int unsigned     GOAL_PERIOD = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               prng_en,
  input  logic [63:0]        prng_word,
  input  logic [COORD_W-1:0] goal_x,
  input  logic [COORD_W-1:0] goal_y,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [COORD_W-1:0] sample_x,
  output logic [COORD_W-1:0] sample_y,
  output logic               sample_is_goal,
  output logic [31:0]        reject_count,
  output logic [1:0]         dbg_state
);

  // Power-of-two masks covering each bound; a bound of 1 gives a zero mask.
  localparam int unsigned X_BITS = $clog2(X_MAX);
  localparam int unsigned Y_BITS = $clog2(Y_MAX);
  localparam logic [63:0] MX     = (64'd1 << X_BITS) - 64'd1;
  localparam logic [63:0] MY     = (64'd1 << Y_BITS) - 64'd1;

  // The goal counter still needs one bit when goal bias is disabled.
  localparam int unsigned GC_W      = (GOAL_PERIOD == 0) ? 1 : $clog2(GOAL_PERIOD + 1);
  localparam int unsigned GOAL_LAST = (GOAL_PERIOD == 0) ? 0 : GOAL_PERIOD - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_valid;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic                r_is_goal;
  logic [31:0]         r_reject_count;
  logic [GC_W-1:0]     r_goal_cnt;

  logic [31:0]         w_cx;
  logic [31:0]         w_cy;
  logic                w_accept;
  logic                w_goal_due;

  // Candidate point from the current word and its in-bounds test.
  always_comb begin
    w_cx       = prng_word[31:0]  & MX[31:0];
    w_cy       = prng_word[63:32] & MY[31:0];
    w_accept   = ({32'd0, w_cx} < X_MAX) && ({32'd0, w_cy} < Y_MAX);
    w_goal_due = (GOAL_PERIOD != 0) && (r_goal_cnt == GC_W'(GOAL_LAST));
  end

  // The generator advances exactly on the cycles whose word is evaluated.
  assign prng_en        = (r_state == S_DRAW);
  assign sample_valid   = r_valid;
  assign sample_x       = r_x;
  assign sample_y       = r_y;
  assign sample_is_goal = r_is_goal;
  assign reject_count   = r_reject_count;
  assign dbg_state      = r_state;

  // Sampling FSM: IDLE decides goal vs draw, DRAW rejects until a hit, HOLD waits for the transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_valid        <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_is_goal      <= 1'b0;
      r_reject_count <= '0;
      r_goal_cnt     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            if (w_goal_due) begin
              r_x       <= goal_x;
              r_y       <= goal_y;
              r_is_goal <= 1'b1;
              r_valid   <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              r_state   <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          if (w_accept) begin
            r_x       <= COORD_W'(w_cx);
            r_y       <= COORD_W'(w_cy);
            r_is_goal <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= S_HOLD;
          end else if (r_reject_count != 32'hFFFF_FFFF) begin
            r_reject_count <= r_reject_count + 32'd1;
          end
        end
        S_HOLD: begin
          if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            if (GOAL_PERIOD != 0) begin
              r_goal_cnt <= r_is_goal ? '0 : r_goal_cnt + GC_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rrt_sample_gen.sv
// Directed bench for rrt_sample_gen with 100x100 workspace (mask 127) and goal every 3rd sample.
module tb_rrt_sample_gen;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          prng_en;
  logic [63:0]   prng_word;
  logic [CW-1:0] goal_x;
  logic [CW-1:0] goal_y;
  logic          sample_valid;
  logic          sample_ready;
  logic [CW-1:0] sample_x;
  logic [CW-1:0] sample_y;
  logic          sample_is_goal;
  logic [31:0]   reject_count;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  logic [63:0] word_q[$];

  rrt_sample_gen #(
    .COORD_W(CW), .X_MAX(100), .Y_MAX(100), .GOAL_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prng_en(prng_en),
    .prng_word(prng_word), .goal_x(goal_x), .goal_y(goal_y),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sample_x), .sample_y(sample_y), .sample_is_goal(sample_is_goal),
    .reject_count(reject_count), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Present the head of the word queue, as prng64 would.
  task automatic show_word();
    prng_word = (word_q.size() > 0) ? word_q[0] : 64'h0;
  endtask

  // One clock: counts prng_en and advances the word stream after a consuming edge.
  task automatic step();
    logic consume;
    consume = prng_en;
    if (consume) en_cnt++;
    @(posedge clk);
    @(negedge clk);
    if (consume && word_q.size() > 0) void'(word_q.pop_front());
    show_word();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", sample_valid); end
    checks++; if (prng_en !== 1'b0) begin errors++; $display("FAIL reset_prng_en got %0b want 0", prng_en); end
    checks++; if (sample_x !== 16'd0 || sample_y !== 16'd0) begin errors++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", sample_x, sample_y); end
    checks++; if (sample_is_goal !== 1'b0) begin errors++; $display("FAIL reset_goal got %0b want 0", sample_is_goal); end
    checks++; if (reject_count !== 32'd0) begin errors++; $display("FAIL reset_rej got %0d want 0", reject_count); end
  endtask

  task automatic test_single_accept();
    int cyc;
    word_q = {64'h0000_0032_0000_0050};
    show_word();
    en_cnt = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    checks++; if (prng_en !== 1'b1 || sample_valid !== 1'b0) begin errors++; $display("FAIL single_draw got en=%0b v=%0b want en=1 v=0", prng_en, sample_valid); end
    cyc = 1;
    while (!sample_valid && cyc < 10) begin step(); cyc++; end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", cyc); end
    checks++; if (sample_x !== 16'd80 || sample_y !== 16'd50 || sample_is_goal !== 1'b0) begin errors++; $display("FAIL single_xy got (%0d,%0d,g%0b) want (80,50,g0)", sample_x, sample_y, sample_is_goal); end
    checks++; if (reject_count !== 32'd0) begin errors++; $display("FAIL single_rej got %0d want 0", reject_count); end
    step();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL single_handshake got %0b want 0", sample_valid); end
    checks++; if (en_cnt !== 1) begin errors++; $display("FAIL single_en_pulses got %0d want 1", en_cnt); end
  endtask

  task automatic test_reject_streak();
    int cyc;
    word_q = {64'h0000_0010_0000_007F, 64'h0000_0064_0000_0001, 64'h0000_0063_0000_0063};
    show_word();
    en_cnt = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    cyc = 1;
    while (!sample_valid && cyc < 10) begin step(); cyc++; end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL streak_latency got %0d want 4", cyc); end
    checks++; if (sample_x !== 16'd99 || sample_y !== 16'd99) begin errors++; $display("FAIL streak_xy got (%0d,%0d) want (99,99)", sample_x, sample_y); end
    checks++; if (reject_count !== 32'd2) begin errors++; $display("FAIL streak_rej got %0d want 2", reject_count); end
    checks++; if (en_cnt !== 3) begin errors++; $display("FAIL streak_en_pulses got %0d want 3", en_cnt); end
    step();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL streak_handshake got %0b want 0", sample_valid); end
  endtask

  // Two random samples are already out, so the third is the goal; then 4,5 random and 6 goal.
  task automatic test_goal();
    int n;
    logic goal_seen [3];
    logic [CW-1:0] x_seen [3];
    goal_x = 16'd7;
    goal_y = 16'd9;
    word_q.delete();
    show_word();
    en_cnt = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    checks++; if (sample_valid !== 1'b1 || sample_is_goal !== 1'b1) begin errors++; $display("FAIL goal_latency got v=%0b g=%0b want v=1 g=1", sample_valid, sample_is_goal); end
    checks++; if (sample_x !== 16'd7 || sample_y !== 16'd9) begin errors++; $display("FAIL goal_xy got (%0d,%0d) want (7,9)", sample_x, sample_y); end
    step();
    checks++; if (en_cnt !== 0 || sample_valid !== 1'b0) begin errors++; $display("FAIL goal_no_draw got en=%0d v=%0b want en=0 v=0", en_cnt, sample_valid); end
    n = 0;
    enable = 1'b1;
    for (int i = 0; i < 30 && n < 3; i++) begin
      if (sample_valid && sample_ready) begin
        goal_seen[n] = sample_is_goal;
        x_seen[n] = sample_x;
        n++;
      end
      step();
    end
    enable = 1'b0;
    step();
    checks++; if (n !== 3) begin errors++; $display("FAIL goal_cycle_count got %0d want 3", n); end
    else begin
      checks++; if (goal_seen[0] !== 1'b0 || goal_seen[1] !== 1'b0 || goal_seen[2] !== 1'b1) begin errors++; $display("FAIL goal_pattern got %0b%0b%0b want 001", goal_seen[0], goal_seen[1], goal_seen[2]); end
      checks++; if (x_seen[0] !== 16'd0 || x_seen[2] !== 16'd7) begin errors++; $display("FAIL goal_sixth_x got %0d/%0d want 0/7", x_seen[0], x_seen[2]); end
    end
  endtask

  task automatic test_backpressure();
    sample_ready = 1'b0;
    word_q = {64'h0000_0005_0000_0004};
    show_word();
    enable = 1'b1;
    step();
    step();
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b want 1", sample_valid); end
    for (int i = 0; i < 10; i++) begin
      enable = ~enable;
      goal_x = goal_x + 16'd3;
      step();
      checks++;
      if (sample_valid !== 1'b1 || sample_x !== 16'd4 || sample_y !== 16'd5 || prng_en !== 1'b0 || sample_is_goal !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%0b (%0d,%0d) en=%0b g=%0b want v=1 (4,5) en=0 g=0", i, sample_valid, sample_x, sample_y, prng_en, sample_is_goal);
      end
    end
    enable = 1'b0;
    sample_ready = 1'b1;
    step();
    checks++; if (sample_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL bp_release got v=%0b st=%0d want v=0 st=0", sample_valid, dbg_state); end
    step();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_single got %0b want 0", sample_valid); end
  endtask

  task automatic test_reset_mid_draw();
    word_q = {64'h7F, 64'h7F, 64'h7F, 64'h7F, 64'h7F};
    show_word();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (sample_valid !== 1'b0 || prng_en !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_draw_ctrl got v=%0b en=%0b st=%0d want 0/0/0", sample_valid, prng_en, dbg_state); end
    checks++; if (sample_x !== 16'd0 || sample_y !== 16'd0 || sample_is_goal !== 1'b0) begin errors++; $display("FAIL rst_draw_xy got (%0d,%0d,g%0b) want (0,0,g0)", sample_x, sample_y, sample_is_goal); end
    checks++; if (reject_count !== 32'd0) begin errors++; $display("FAIL rst_draw_rej got %0d want 0", reject_count); end
    word_q = {64'h0000_0002_0000_0003};
    show_word();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    checks++; if (sample_valid !== 1'b1 || sample_x !== 16'd3 || sample_y !== 16'd2 || sample_is_goal !== 1'b0) begin errors++; $display("FAIL rst_resume got v=%0b (%0d,%0d,g%0b) want v=1 (3,2,g0)", sample_valid, sample_x, sample_y, sample_is_goal); end
    step();
  endtask

  task automatic test_saturation();
    force dut.r_reject_count = 32'hFFFF_FFFE;
    step();
    release dut.r_reject_count;
    step();
    checks++; if (reject_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got %h want fffffffe", reject_count); end
    word_q = {64'h7F, 64'h7F, 64'h0000_0001_0000_0001};
    show_word();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    checks++; if (reject_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach got %h want ffffffff", reject_count); end
    step();
    checks++; if (reject_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h want ffffffff", reject_count); end
    step();
    checks++; if (sample_valid !== 1'b1 || sample_x !== 16'd1 || reject_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_accept got v=%0b x=%0d rej=%h want v=1 x=1 rej=ffffffff", sample_valid, sample_x, reject_count); end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    sample_ready = 1'b1;
    goal_x = 16'd0;
    goal_y = 16'd0;
    prng_word = 64'h0;
    @(negedge clk);
    test_reset();
    test_single_accept();
    test_reject_streak();
    test_goal();
    test_backpressure();
    test_reset_mid_draw();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
